levenshtein_pattern_loader: RTL and testbench
=============================================

Name: levenshtein_pattern_loader

Overview:
- Host-facing preparation stage that sits directly upstream of levenshtein_controller.
- Host writes the search word (1..15 chars) into a local buffer and issues start.
- The block clears the 256-entry pattern-match (Peq) vector table in external memory, then writes one 16-bit vector per word character.
- It then programs the controller's LENGTH, MASK and INITIAL_VP registers over a second Wishbone master, and can optionally enable the controller.

Parameters:
MASTER_ADDR_WIDTH, 24, address width of memory master; table entry c occupies bytes {c,0} (hi) and {c,1} (lo), zero-extended.
SLAVE_ADDR_WIDTH, 24, address width of host slave; only adr[4:0] decoded.
CFG_ADDR_WIDTH, 3, address width of controller-config master.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host slave strobes
wbs_adr_i  in  SLAVE_ADDR_WIDTH  host address
wbs_dat_i  in  8  host write data
wbs_ack_o  out  1  registered ack
wbs_err_o, wbs_rty_o  out  1 each  tied 0
wbs_dat_o  out  8  read data
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  memory master; we always 1
wbm_adr_o  out  MASTER_ADDR_WIDTH  table address
wbm_dat_o  out  8  vector byte
wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  memory responses
wbc_cyc_o, wbc_stb_o, wbc_we_o  out  1 each  controller-config master; we always 1
wbc_adr_o  out  CFG_ADDR_WIDTH  controller register index
wbc_dat_o  out  8  register value
wbc_ack_i, wbc_err_i, wbc_rty_i  in  1 each  controller responses

Behaviour:
- Reset: all cyc/stb/ack low; state IDLE; busy = error = done = 0; length = 0; buffer contents undefined.
- Slave: one-cycle ack pulse one cycle after cyc&stb&!ack, same as the controller. Address map:
  - 0x00 CTRL. Write: bit0 start, bit1 autostart. Read: {5'b0, done, error, busy}.
  - 0x01 LENGTH[3:0].
  - 0x10..0x1E char[adr[3:0]].
  - Read data for unmapped addresses is 0.
- While busy, writes to LENGTH and chars are acked and ignored; start is ignored.
- Start sequence:
  - Start clears error and done.
  - If length == 0, or any char[0..length-1] is 0xFE or 0xFF: error = 1, no master cycles issued.
  - Otherwise busy = 1 and the FSM enters CLEAR.
- FSM IDLE -> CLEAR -> LOAD_HI -> LOAD_LO -> CFG -> IDLE.
- Master handshake, both ports:
  - Assert cyc = stb with addr/data stable in the cycle after a transaction is selected.
  - Hold until ack. On ack, drop cyc for exactly one cycle, then issue the next transaction. Minimum 2 cycles per write.
  - err or rty: drop cyc, error = 1, busy = 0, return to IDLE; no further writes.
- CLEAR: 9-bit counter k = 0..511; write 0x00 to address k. Total 512 writes.
- LOAD: for i = 0..length-1:
  - vec[j] = (char[j] == char[i]) for j < length, 0 above; combinational 15-way compare.
  - Write vec[15:8] to {char[i],0}, then vec[7:0] to {char[i],1}.
  - Duplicate chars rewrite the identical value.
- CFG writes, in order:
  - LENGTH(1) = length
  - MASK_HI(2) / MASK_LO(3) = 1 << (length-1)
  - INITIAL_VP_HI(4) / INITIAL_VP_LO(5) = (1 << length) - 1
  - then, if autostart, CTRL(0) = 0x01.
- Completion: busy = 0, done = 1.
- Reset mid-operation: cyc drops in the next cycle and nothing is retried.
- Write data is fully determined before cyc rises. Bit i of a vector corresponds to word position i.

Decomposition:
- Package levenshtein_pkg:
  - controller register indices ADDR_CTRL..ADDR_INITIAL_VP_LO
  - terminator codes 0xFE and 0xFF
  - BITVECTOR_WIDTH = 16, MAX_WORD_LENGTH = 15
  - loader register map and FSM state enum
- Sub-module wb_write_master: single-write handshake engine (req, addr, data -> cyc/stb, done/fail pulses). Instantiated twice, once for wbm and once for wbc.

Test Plan:
- Word "ab", length 2, start -> 512 zero writes to 0x000..0x1FF; then 0x0C2 = 0x00, 0x0C3 = 0x01, 0x0C4 = 0x00, 0x0C5 = 0x02; cfg writes (1,2),(2,0),(3,2),(4,0),(5,3); CTRL reads 0x04.
- Word "aba", autostart -> 0x0C3 = 0x05 written twice, 0x0C5 = 0x02; final cfg write (0,0x01).
- Length 15, all 'x' -> 0x0F0 = 0x7F, 0x0F1 = 0xFF; MASK = 0x4000; VP = 0x7FFF.
- Length 0, or char 0xFE -> no cyc on either master; CTRL reads 0x02.
- wbm_err_i on clear write k = 37 -> cyc drops, no further writes, CTRL reads 0x02; a subsequent valid start completes normally.
- Ack stalls of 0..5 cycles, plus a second start while busy -> write sequence identical, extra start ignored; reset mid-LOAD -> cyc low next cycle, CTRL reads 0x00.

Source files
------------

// File: rtl/levenshtein_pkg.sv
// Shared constants, register maps and FSM encoding for the Levenshtein pattern loader
// and the downstream levenshtein_controller configuration interface.
package levenshtein_pkg;

    localparam int BITVECTOR_WIDTH = 16;
    localparam int MAX_WORD_LENGTH = 15;

    // Controller register indices written over the config master
    localparam logic [2:0] ADDR_CTRL          = 3'd0;
    localparam logic [2:0] ADDR_LENGTH        = 3'd1;
    localparam logic [2:0] ADDR_MASK_HI       = 3'd2;
    localparam logic [2:0] ADDR_MASK_LO       = 3'd3;
    localparam logic [2:0] ADDR_INITIAL_VP_HI = 3'd4;
    localparam logic [2:0] ADDR_INITIAL_VP_LO = 3'd5;

    localparam logic [7:0] CHAR_TERM_FE = 8'hFE;
    localparam logic [7:0] CHAR_TERM_FF = 8'hFF;

    // Loader host register map (adr[4:0]); chars live at 0x10..0x1E
    localparam logic [4:0] LDR_REG_CTRL   = 5'h00;
    localparam logic [4:0] LDR_REG_LENGTH = 5'h01;

    localparam logic [8:0] CLEAR_LAST = 9'd511;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_LOAD_LO = 3'd3,
        ST_CFG     = 3'd4
    } loader_state_e;

    function automatic logic is_terminator(input logic [7:0] c);
        return (c == CHAR_TERM_FE) || (c == CHAR_TERM_FF);
    endfunction

endpackage

// File: rtl/wb_write_master.sv
// Single-write Wishbone master: latches addr/data on req while idle, holds cyc/stb
// until a response, and reports done (ack) or fail (err/rty) in that same cycle.
module wb_write_master #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            data,
    output logic                  done,
    output logic                  fail,
    output logic                  cyc,
    output logic                  stb,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] adr,
    output logic [7:0]            dat,
    input  logic                  ack,
    input  logic                  err,
    input  logic                  rty
);

    logic                  cyc_r;
    logic [ADDR_WIDTH-1:0] adr_r;
    logic [7:0]            dat_r;
    logic                  resp_s;

    assign resp_s = cyc_r & (ack | err | rty);
    assign fail   = cyc_r & (err | rty);
    assign done   = cyc_r & ack & ~(err | rty);

    assign cyc = cyc_r;
    assign stb = cyc_r;
    assign we  = 1'b1;
    assign adr = adr_r;
    assign dat = dat_r;

    // Bus cycle register; the cycle after any response is always idle, giving the one-cycle gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_r <= 1'b0;
            adr_r <= '0;
            dat_r <= 8'h00;
        end else if (resp_s) begin
            cyc_r <= 1'b0;
        end else if (!cyc_r && req) begin
            cyc_r <= 1'b1;
            adr_r <= addr;
            dat_r <= data;
        end else begin
            cyc_r <= cyc_r;
        end
    end

endmodule

// File: rtl/levenshtein_pattern_loader.sv
// Host-programmed loader: clears the Peq table, writes one match vector per word
// character, then programs the controller's LENGTH/MASK/INITIAL_VP registers.
module levenshtein_pattern_loader
    import levenshtein_pkg::*;
#(
    parameter int MASTER_ADDR_WIDTH = 24,
    parameter int SLAVE_ADDR_WIDTH  = 24,
    parameter int CFG_ADDR_WIDTH    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
    input  logic [7:0]                   wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic                         wbs_rty_o,
    output logic [7:0]                   wbs_dat_o,
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic                         wbm_we_o,
    output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [7:0]                   wbm_dat_o,
    input  logic                         wbm_ack_i,
    input  logic                         wbm_err_i,
    input  logic                         wbm_rty_i,
    output logic                         wbc_cyc_o,
    output logic                         wbc_stb_o,
    output logic                         wbc_we_o,
    output logic [CFG_ADDR_WIDTH-1:0]    wbc_adr_o,
    output logic [7:0]                   wbc_dat_o,
    input  logic                         wbc_ack_i,
    input  logic                         wbc_err_i,
    input  logic                         wbc_rty_i
);

    logic                         ack_r;
    logic [7:0]                   rdata_r;
    logic [3:0]                   length_r;
    logic                         autostart_r;
    logic [7:0]                   chars_r [BITVECTOR_WIDTH];
    loader_state_e                state_r, state_s;
    logic [8:0]                   cnt_r, cnt_s;
    logic                         error_r, error_s, done_r, done_s;

    logic [4:0]                   reg_adr_s;
    logic                         char_sel_s, host_acc_s, host_wr_s, busy_s, start_s, invalid_s;
    logic [7:0]                   rd_data_s, cur_char_s;
    logic [BITVECTOR_WIDTH-1:0]   vec_s, mask_s, vp_s;
    logic                         mem_req_s, mem_done_s, mem_fail_s;
    logic [MASTER_ADDR_WIDTH-1:0] mem_addr_s;
    logic [7:0]                   mem_data_s;
    logic                         cfg_req_s, cfg_done_s, cfg_fail_s;
    logic [CFG_ADDR_WIDTH-1:0]    cfg_addr_s;
    logic [7:0]                   cfg_data_s;
    logic                         unused_adr_s;

    assign reg_adr_s    = wbs_adr_i[4:0];
    assign unused_adr_s = ^wbs_adr_i[SLAVE_ADDR_WIDTH-1:5];
    assign char_sel_s   = reg_adr_s[4] & (reg_adr_s[3:0] != 4'hF);
    assign host_acc_s   = wbs_cyc_i & wbs_stb_i & ~ack_r;
    assign host_wr_s    = host_acc_s & wbs_we_i;
    assign busy_s       = (state_r != ST_IDLE);
    assign start_s      = host_wr_s & (reg_adr_s == LDR_REG_CTRL) & wbs_dat_i[0] & ~busy_s;

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = rdata_r;
    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;

    // Host read mux.
    always_comb begin
        rd_data_s = 8'h00;
        if (reg_adr_s == LDR_REG_CTRL) begin
            rd_data_s = {5'b00000, done_r, error_r, busy_s};
        end else if (reg_adr_s == LDR_REG_LENGTH) begin
            rd_data_s = {4'h0, length_r};
        end else if (char_sel_s) begin
            rd_data_s = chars_r[reg_adr_s[3:0]];
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Host slave: registered ack and read data; configuration is frozen while busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r       <= 1'b0;
            rdata_r     <= 8'h00;
            length_r    <= 4'h0;
            autostart_r <= 1'b0;
        end else begin
            ack_r <= host_acc_s;
            if (host_acc_s) begin
                rdata_r <= rd_data_s;
            end
            if (host_wr_s && !busy_s) begin
                if (reg_adr_s == LDR_REG_CTRL) begin
                    autostart_r <= wbs_dat_i[1];
                end else if (reg_adr_s == LDR_REG_LENGTH) begin
                    length_r <= wbs_dat_i[3:0];
                end
            end
        end
    end

    // Word buffer carries no reset value; entry 15 is never written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && host_wr_s && !busy_s && char_sel_s) begin
            chars_r[reg_adr_s[3:0]] <= wbs_dat_i;
        end
    end

    // Match vector for the current character, word validation and controller constants.
    always_comb begin
        cur_char_s = chars_r[cnt_r[3:0]];
        vec_s      = '0;
        invalid_s  = (length_r == 4'd0);
        for (int j = 0; j < MAX_WORD_LENGTH; j++) begin
            if (j < int'(length_r)) begin
                vec_s[j] = (chars_r[j] == cur_char_s);
                invalid_s = invalid_s | is_terminator(chars_r[j]);
            end else begin
                vec_s[j] = 1'b0;
            end
        end
        mask_s = 16'h0001 << (length_r - 4'd1);
        vp_s   = (16'h0001 << length_r) - 16'h0001;
    end

    // FSM next state, sequencing counter and master request selection.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        error_s    = error_r;
        done_s     = done_r;
        mem_req_s  = 1'b0;
        mem_addr_s = '0;
        mem_data_s = 8'h00;
        cfg_req_s  = 1'b0;
        cfg_addr_s = '0;
        cfg_data_s = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    done_s  = 1'b0;
                    error_s = invalid_s;
                    cnt_s   = 9'd0;
                    state_s = invalid_s ? ST_IDLE : ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                mem_req_s  = 1'b1;
                mem_addr_s = MASTER_ADDR_WIDTH'(cnt_r);
                if (mem_done_s) begin
                    cnt_s   = (cnt_r == CLEAR_LAST) ? 9'd0 : cnt_r + 9'd1;
                    state_s = (cnt_r == CLEAR_LAST) ? ST_LOAD_HI : ST_CLEAR;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_LOAD_HI: begin
                mem_req_s  = 1'b1;
                mem_addr_s = MASTER_ADDR_WIDTH'({cur_char_s, 1'b0});
                mem_data_s = vec_s[15:8];
                if (mem_done_s) begin
                    state_s = ST_LOAD_LO;
                end else begin
                    state_s = ST_LOAD_HI;
                end
            end
            ST_LOAD_LO: begin
                mem_req_s  = 1'b1;
                mem_addr_s = MASTER_ADDR_WIDTH'({cur_char_s, 1'b1});
                mem_data_s = vec_s[7:0];
                if (mem_done_s) begin
                    if (cnt_r[3:0] == (length_r - 4'd1)) begin
                        state_s = ST_CFG;
                        cnt_s   = 9'd0;
                    end else begin
                        state_s = ST_LOAD_HI;
                        cnt_s   = cnt_r + 9'd1;
                    end
                end else begin
                    state_s = ST_LOAD_LO;
                end
            end
            ST_CFG: begin
                cfg_req_s = 1'b1;
                case (cnt_r[2:0])
                    3'd0: begin cfg_addr_s = CFG_ADDR_WIDTH'(ADDR_LENGTH);        cfg_data_s = {4'h0, length_r}; end
                    3'd1: begin cfg_addr_s = CFG_ADDR_WIDTH'(ADDR_MASK_HI);       cfg_data_s = mask_s[15:8];     end
                    3'd2: begin cfg_addr_s = CFG_ADDR_WIDTH'(ADDR_MASK_LO);       cfg_data_s = mask_s[7:0];      end
                    3'd3: begin cfg_addr_s = CFG_ADDR_WIDTH'(ADDR_INITIAL_VP_HI); cfg_data_s = vp_s[15:8];       end
                    3'd4: begin cfg_addr_s = CFG_ADDR_WIDTH'(ADDR_INITIAL_VP_LO); cfg_data_s = vp_s[7:0];        end
                    default: begin cfg_addr_s = CFG_ADDR_WIDTH'(ADDR_CTRL);       cfg_data_s = 8'h01;            end
                endcase
                if (cfg_done_s) begin
                    if ((cnt_r[2:0] == 3'd5) || ((cnt_r[2:0] == 3'd4) && !autostart_r)) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                        cnt_s   = 9'd0;
                    end else begin
                        cnt_s = cnt_r + 9'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 9'd0;
            end
        endcase
        if (mem_fail_s || cfg_fail_s) begin
            state_s = ST_IDLE;
            error_s = 1'b1;
            cnt_s   = 9'd0;
        end else begin
            error_s = error_s;
        end
    end

    // FSM state and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 9'd0;
            error_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            error_r <= error_s;
            done_r  <= done_s;
        end
    end

    wb_write_master #(.ADDR_WIDTH(MASTER_ADDR_WIDTH)) u_mem_master (
        .clk_i (clk_i),      .rst_i (rst_i),
        .req   (mem_req_s),  .addr  (mem_addr_s), .data (mem_data_s),
        .done  (mem_done_s), .fail  (mem_fail_s),
        .cyc   (wbm_cyc_o),  .stb   (wbm_stb_o),  .we   (wbm_we_o),
        .adr   (wbm_adr_o),  .dat   (wbm_dat_o),
        .ack   (wbm_ack_i),  .err   (wbm_err_i),  .rty  (wbm_rty_i)
    );

    wb_write_master #(.ADDR_WIDTH(CFG_ADDR_WIDTH)) u_cfg_master (
        .clk_i (clk_i),      .rst_i (rst_i),
        .req   (cfg_req_s),  .addr  (cfg_addr_s), .data (cfg_data_s),
        .done  (cfg_done_s), .fail  (cfg_fail_s),
        .cyc   (wbc_cyc_o),  .stb   (wbc_stb_o),  .we   (wbc_we_o),
        .adr   (wbc_adr_o),  .dat   (wbc_dat_o),
        .ack   (wbc_ack_i),  .err   (wbc_err_i),  .rty  (wbc_rty_i)
    );

endmodule

// File: tb/tb_levenshtein_pattern_loader.sv
// Randomized self-checking bench: stalling memory/config slaves compare every write
// against a word-level reference model of the expected table and register contents.
module tb_levenshtein_pattern_loader;

    localparam int MAW = 24;
    localparam int SAW = 24;
    localparam int CAW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           wbs_cyc, wbs_stb, wbs_we;
    logic [SAW-1:0] wbs_adr;
    logic [7:0]     wbs_wdat;
    logic           wbs_ack, wbs_err, wbs_rty;
    logic [7:0]     wbs_rdat;
    logic           wbm_cyc, wbm_stb, wbm_we;
    logic [MAW-1:0] wbm_adr;
    logic [7:0]     wbm_dat;
    logic           wbm_ack, wbm_err, wbm_rty;
    logic           wbc_cyc, wbc_stb, wbc_we;
    logic [CAW-1:0] wbc_adr;
    logic [7:0]     wbc_dat;
    logic           wbc_ack, wbc_err, wbc_rty;

    int errors = 0;
    int checks = 0;
    int max_stall = 0;
    int err_at = -1;
    int mem_seen = 0;
    int cfg_seen = 0;
    logic [31:0] exp_mem[$];
    logic [31:0] exp_cfg[$];
    logic [7:0]  word_buf [15];

    always #5 clk = ~clk;

    levenshtein_pattern_loader dut (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we),
        .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_wdat),
        .wbs_ack_o(wbs_ack), .wbs_err_o(wbs_err), .wbs_rty_o(wbs_rty), .wbs_dat_o(wbs_rdat),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty),
        .wbc_cyc_o(wbc_cyc), .wbc_stb_o(wbc_stb), .wbc_we_o(wbc_we),
        .wbc_adr_o(wbc_adr), .wbc_dat_o(wbc_dat),
        .wbc_ack_i(wbc_ack), .wbc_err_i(wbc_err), .wbc_rty_i(wbc_rty)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Table memory slave with random ack stalls and optional error injection.
    initial begin : mem_slave
        bit pending;
        int stall;
        logic [31:0] e;
        pending = 1'b0; stall = 0;
        wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rty = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pending = 1'b0; wbm_ack = 1'b0; wbm_err = 1'b0;
            end else if (wbm_ack || wbm_err) begin
                wbm_ack = 1'b0; wbm_err = 1'b0;
            end else if (wbm_cyc) begin
                if (!pending) begin
                    pending = 1'b1;
                    stall = $urandom_range(0, max_stall);
                end
                if (stall == 0) begin
                    pending = 1'b0;
                    e = (exp_mem.size() > 0) ? exp_mem.pop_front() : 32'hDEADBEEF;
                    check_eq("mem_write", {wbm_adr, wbm_dat}, e);
                    check_eq("mem_stb_we", {30'd0, wbm_stb, wbm_we}, 32'd3);
                    if (mem_seen == err_at) wbm_err = 1'b1;
                    else wbm_ack = 1'b1;
                    mem_seen++;
                end else begin
                    stall--;
                end
            end
        end
    end

    // Controller config slave with random ack stalls.
    initial begin : cfg_slave
        bit pending;
        int stall;
        logic [31:0] e;
        pending = 1'b0; stall = 0;
        wbc_ack = 1'b0; wbc_err = 1'b0; wbc_rty = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pending = 1'b0; wbc_ack = 1'b0;
            end else if (wbc_ack) begin
                wbc_ack = 1'b0;
            end else if (wbc_cyc) begin
                if (!pending) begin
                    pending = 1'b1;
                    stall = $urandom_range(0, max_stall);
                end
                if (stall == 0) begin
                    pending = 1'b0;
                    e = (exp_cfg.size() > 0) ? exp_cfg.pop_front() : 32'hDEADBEEF;
                    check_eq("cfg_write", {21'd0, wbc_adr, wbc_dat}, e);
                    check_eq("cfg_stb_we", {30'd0, wbc_stb, wbc_we}, 32'd3);
                    wbc_ack = 1'b1;
                    cfg_seen++;
                end else begin
                    stall--;
                end
            end
        end
    end

    task automatic host_xfer(input bit we, input logic [4:0] a, input logic [7:0] d, output logic [7:0] q);
        @(posedge clk); #1;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
        wbs_adr = {19'($urandom), a};
        wbs_wdat = d;
        for (int n = 0; n < 8 && !wbs_ack; n++) begin
            @(posedge clk); #1;
        end
        if (!wbs_ack) check_eq("host_ack_timeout", 32'd0, 32'd1);
        q = wbs_rdat;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        logic [7:0] q;
        host_xfer(1'b1, a, d, q);
    endtask

    task automatic host_read(input logic [4:0] a, output logic [7:0] q);
        host_xfer(1'b0, a, 8'h00, q);
    endtask

    // Reference model: expected write streams derived from the word itself.
    task automatic build_expected(input int len, input bit auto_en, output bit bad);
        logic [15:0] vec, mask, vp;
        exp_mem.delete(); exp_cfg.delete();
        mem_seen = 0; cfg_seen = 0;
        bad = (len == 0);
        for (int j = 0; j < len; j++) if (word_buf[j] >= 8'hFE) bad = 1'b1;
        if (!bad) begin
            for (int k = 0; k < 512; k++) exp_mem.push_back({24'(k), 8'h00});
            for (int i = 0; i < len; i++) begin
                vec = 16'h0000;
                for (int j = 0; j < len; j++) if (word_buf[j] == word_buf[i]) vec[j] = 1'b1;
                exp_mem.push_back({15'd0, word_buf[i], 1'b0, vec[15:8]});
                exp_mem.push_back({15'd0, word_buf[i], 1'b1, vec[7:0]});
            end
            mask = 16'(1 << (len - 1));
            vp   = 16'((1 << len) - 1);
            exp_cfg.push_back({21'd0, 3'd1, 8'(len)});
            exp_cfg.push_back({21'd0, 3'd2, mask[15:8]});
            exp_cfg.push_back({21'd0, 3'd3, mask[7:0]});
            exp_cfg.push_back({21'd0, 3'd4, vp[15:8]});
            exp_cfg.push_back({21'd0, 3'd5, vp[7:0]});
            if (auto_en) exp_cfg.push_back({21'd0, 3'd0, 8'h01});
        end
    endtask

    task automatic load_word(input int len);
        host_write(5'h01, 8'(len));
        for (int j = 0; j < 15; j++) host_write(5'h10 + 5'(j), word_buf[j]);
    endtask

    task automatic wait_idle(output logic [7:0] ctrl);
        ctrl = 8'h01;
        for (int n = 0; n < 6000 && ctrl[0]; n++) host_read(5'h00, ctrl);
        if (ctrl[0]) check_eq("busy_timeout", {24'd0, ctrl}, 32'd0);
    endtask

    task automatic run_op(input int len, input bit auto_en, input int stall, input bit extra);
        bit bad;
        bit fault;
        logic [7:0] ctrl, d;
        load_word(len);
        max_stall = stall;
        build_expected(len, auto_en, bad);
        fault = (err_at >= 0) && !bad;
        if (fault) begin
            while (exp_mem.size() > err_at + 1) void'(exp_mem.pop_back());
            exp_cfg.delete();
        end
        host_write(5'h00, {6'd0, auto_en, 1'b1});
        if (extra && !bad && !fault) begin
            repeat (40) @(posedge clk);
            host_write(5'h00, {6'd0, auto_en, 1'b1});
            host_write(5'h01, 8'd3);
            host_write(5'h10, 8'h5A);
        end
        wait_idle(ctrl);
        repeat (12) @(posedge clk);
        #1;
        check_eq("ctrl_status", {24'd0, ctrl}, (bad || fault) ? 32'h02 : 32'h04);
        check_eq("mem_remaining", 32'(exp_mem.size()), 32'd0);
        check_eq("cfg_remaining", 32'(exp_cfg.size()), 32'd0);
        check_eq("cyc_idle", {30'd0, wbm_cyc, wbc_cyc}, 32'd0);
        host_read(5'h01, d);
        check_eq("length_rb", {24'd0, d}, 32'(len));
    endtask

    initial begin : main
        logic [7:0] d;
        bit bad;
        rst = 1'b1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_adr = '0; wbs_wdat = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("reset_cyc", {29'd0, wbm_cyc, wbc_cyc, wbs_ack}, 32'd0);
        check_eq("slave_err_rty", {30'd0, wbs_err, wbs_rty}, 32'd0);
        host_read(5'h00, d);
        check_eq("reset_ctrl", {24'd0, d}, 32'h00);
        @(posedge clk); #1;
        check_eq("ack_pulse", {31'd0, wbs_ack}, 32'd0);
        host_read(5'h01, d);
        check_eq("reset_length", {24'd0, d}, 32'h00);
        host_read(5'h1F, d);
        check_eq("unmapped_rd", {24'd0, d}, 32'h00);

        for (int j = 0; j < 15; j++) word_buf[j] = 8'h7A;
        word_buf[0] = 8'h61; word_buf[1] = 8'h62;
        run_op(2, 1'b0, 0, 1'b0);
        word_buf[2] = 8'h61;
        run_op(3, 1'b1, 0, 1'b0);
        for (int j = 0; j < 15; j++) word_buf[j] = 8'h78;
        run_op(15, 1'b0, 1, 1'b0);

        run_op(0, 1'b0, 0, 1'b0);
        word_buf[0] = 8'h61; word_buf[1] = 8'hFE;
        run_op(2, 1'b0, 0, 1'b0);
        word_buf[5] = 8'hFF;
        run_op(3, 1'b0, 0, 1'b0);
        run_op(1, 1'b0, 0, 1'b0);

        word_buf[0] = 8'h61; word_buf[1] = 8'h62;
        err_at = 37;
        run_op(2, 1'b0, 0, 1'b0);
        err_at = -1;
        run_op(2, 1'b0, 0, 1'b0);

        word_buf[2] = 8'h61; word_buf[3] = 8'h63;
        run_op(4, 1'b1, 3, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 15; j++) word_buf[j] = 8'h61 + 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) word_buf[$urandom_range(0, 14)] = 8'hFE + 8'($urandom_range(0, 1));
            run_op($urandom_range(1, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        for (int j = 0; j < 15; j++) word_buf[j] = 8'h61 + 8'(j % 3);
        load_word(6);
        max_stall = 2;
        build_expected(6, 1'b0, bad);
        host_write(5'h00, 8'h01);
        for (int n = 0; n < 20000 && mem_seen < 515; n++) @(posedge clk);
        check_eq("reach_load", 32'(mem_seen >= 515), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check_eq("reset_mid_load_cyc", {30'd0, wbm_cyc, wbc_cyc}, 32'd0);
        rst = 1'b0;
        exp_mem.delete(); exp_cfg.delete();
        host_read(5'h00, d);
        check_eq("reset_mid_load_ctrl", {24'd0, d}, 32'h00);
        repeat (20) @(posedge clk);

        run_op(5, 1'b1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
